// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame types and timing helpers
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, ticks on the last clock of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stops
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  // The done/IDLE cycle is the final clock of the last stop bit, so the
  // last stop bit ends one count early and back-to-back frames have no gap.
  localparam logic [CW-1:0] STOP_END  = CW'(CPB - 2);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          tick;
  logic [CW-1:0] baud_cnt;

  uart_baud_gen #(
    .CLKS_PER_BIT(CPB)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q != IDLE),
    .clr_i (state_q == IDLE),
    .tick_o(tick),
    .cnt_o (baud_cnt)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          shift_d   = tx_data_i;
          parity_d  = (^tx_data_i) ^ (PARITY_ODD != 0);
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (bit_cnt_q == LAST_STOP && baud_cnt == STOP_END) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is registered from the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready_o = (state_q == IDLE);
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx in four frame configurations
module tb_uart_tx;

  localparam int CPB = 104;
  localparam int N   = 4;
  // Instances: 0 default, 1 even parity, 2 odd parity, 3 two stop bits.
  localparam logic [N-1:0] PE_V  = 4'b0110;
  localparam logic [N-1:0] PO_V  = 4'b0100;
  localparam logic [N-1:0] SB2_V = 4'b1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data [N];
  logic [N-1:0] valid;
  logic [N-1:0] tx_w, ready_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ  (1000000),
      .BAUD_RATE (9600),
      .STOP_BITS (SB2_V[g] ? 2 : 1),
      .PARITY_EN (int'(PE_V[g])),
      .PARITY_ODD(int'(PO_V[g]))
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .tx_data_i (data[g]),
      .tx_valid_i(valid[g]),
      .tx_ready_o(ready_w[g]),
      .tx_o      (tx_w[g]),
      .tx_busy_o (busy_w[g]),
      .tx_done_o (done_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int k);
    return (9 + int'(PE_V[k]) + (SB2_V[k] ? 2 : 1)) * CPB;
  endfunction

  // Expected line level c clocks after the start bit began.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int c);
    int idx;
    idx = c / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PE_V[k] && idx == 9) return (^b) ^ PO_V[k];
    return 1'b1;
  endfunction

  task automatic start_frame(input int k, input logic [7:0] b);
    int n;
    n = 0;
    while (!ready_w[k] && n < 3000) begin
      step();
      n++;
    end
    check($sformatf("k%0d_ready_before_start", k), 32'(ready_w[k]), 32'd1);
    data[k]  = b;
    valid[k] = 1'b1;
    step();
  endtask

  // Called on the first clock of a frame; returns on its last (done) clock.
  // mode: 0 quiet, 1 random valid/data noise, 2 valid held high.
  task automatic watch_frame(input int k, input logic [7:0] b, input int mode,
                             input logic nxt_v, input logic [7:0] nxt_d,
                             output logic [11:0] mid);
    int  len;
    int  bad;
    int  first_bad;
    logic last;
    len = frame_len(k);
    bad = 0;
    first_bad = -1;
    mid = '0;
    for (int c = 0; c < len; c++) begin
      last = (c == len - 1);
      if (tx_w[k] !== exp_bit(k, b, c) || ready_w[k] !== last ||
          busy_w[k] !== !last || done_w[k] !== last) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (c % CPB == CPB / 2) mid[c / CPB] = tx_w[k];
      if (last) begin
        valid[k] = nxt_v;
        data[k]  = nxt_d;
      end else if (mode == 1) begin
        valid[k] = ($urandom_range(0, 7) == 0);
        data[k]  = valid[k] ? 8'h77 : 8'($urandom);
      end else if (mode == 2) begin
        valid[k] = 1'b1;
      end else begin
        valid[k] = 1'b0;
      end
      if (!last) step();
    end
    check($sformatf("k%0d_frame_%02h_bad_cycles(first@%0d)", k, b, first_bad), bad, 0);
  endtask

  task automatic quiet_after(input int k);
    step();
    check($sformatf("k%0d_done_one_cycle", k), 32'(done_w[k]), 32'd0);
    check($sformatf("k%0d_idle_line", k), 32'(tx_w[k]), 32'd1);
  endtask

  initial begin
    logic [11:0] mid;
    logic [7:0]  rb;
    int          pulses;
    rst   = 1'b1;
    valid = '0;
    for (int k = 0; k < N; k++) data[k] = 8'h00;
    repeat (3) step();
    for (int k = 0; k < N; k++) begin
      check($sformatf("k%0d_rst_tx", k),    32'(tx_w[k]),    32'd1);
      check($sformatf("k%0d_rst_ready", k), 32'(ready_w[k]), 32'd1);
      check($sformatf("k%0d_rst_busy", k),  32'(busy_w[k]),  32'd0);
      check($sformatf("k%0d_rst_done", k),  32'(done_w[k]),  32'd0);
    end

    // Reset and valid together: byte must not be taken.
    valid[0] = 1'b1;
    data[0]  = 8'h5A;
    step();
    valid[0] = 1'b0;
    rst      = 1'b0;
    step();
    check("rst_beats_valid_tx",    32'(tx_w[0]),    32'd1);
    check("rst_beats_valid_ready", 32'(ready_w[0]), 32'd1);

    // Default frame with busy-time noise on valid/data.
    start_frame(0, 8'hA5);
    watch_frame(0, 8'hA5, 1, 1'b0, 8'h00, mid);
    check("a5_start_bit", 32'(mid[0]),   32'd0);
    check("a5_data_bits", 32'(mid[8:1]), 32'hA5);
    check("a5_stop_bit",  32'(mid[9]),   32'd1);
    quiet_after(0);

    // Back-to-back with valid held high.
    start_frame(0, 8'h00);
    watch_frame(0, 8'h00, 2, 1'b1, 8'hFF, mid);
    step();
    watch_frame(0, 8'hFF, 0, 1'b0, 8'h00, mid);
    check("b2b_ff_data_bits", 32'(mid[8:1]), 32'hFF);
    quiet_after(0);

    // Parity configurations.
    start_frame(1, 8'hA5);
    watch_frame(1, 8'hA5, 0, 1'b0, 8'h00, mid);
    check("even_a5_parity", 32'(mid[9]), 32'd0);
    quiet_after(1);
    start_frame(1, 8'h01);
    watch_frame(1, 8'h01, 1, 1'b0, 8'h00, mid);
    check("even_01_parity", 32'(mid[9]), 32'd1);
    quiet_after(1);
    start_frame(2, 8'hA5);
    watch_frame(2, 8'hA5, 1, 1'b0, 8'h00, mid);
    check("odd_a5_parity", 32'(mid[9]), 32'd1);
    quiet_after(2);

    // Two stop bits.
    start_frame(3, 8'h3C);
    watch_frame(3, 8'h3C, 0, 1'b0, 8'h00, mid);
    check("stop2_3c_data", 32'(mid[8:1]), 32'h3C);
    check("stop2_first",   32'(mid[9]),   32'd1);
    check("stop2_second",  32'(mid[10]),  32'd1);
    quiet_after(3);

    // Reset in the middle of data bit 3.
    start_frame(0, 8'h55);
    valid[0] = 1'b0;
    repeat (4 * CPB + 50) step();
    check("abort_pre_bit3", 32'(tx_w[0]), 32'(exp_bit(0, 8'h55, 4 * CPB + 50)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_tx_high", 32'(tx_w[0]),    32'd1);
    check("abort_ready",   32'(ready_w[0]), 32'd1);
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) pulses++;
      step();
    end
    check("abort_no_done_line_idle", pulses, 0);
    start_frame(0, 8'h0F);
    watch_frame(0, 8'h0F, 0, 1'b0, 8'h00, mid);
    quiet_after(0);

    // Random bytes on every configuration.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 2; i++) begin
        rb = 8'($urandom);
        start_frame(k, rb);
        watch_frame(k, rb, 1, 1'b0, 8'h00, mid);
        quiet_after(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
